sram_bank_arbiter: RTL and testbench

//  Shares one sram_bank instance (1-cycle read latency) between NUM_REQ requesters.

---
 rtl/sram_bank_arbiter_if.sv | 31 +++
 rtl/sram_bank_arbiter.sv | 110 +++++++++++
 tb/tb_sram_bank_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_arbiter_if.sv
// Request/response bus between NUM_REQ requesters, the arbiter and one SRAM bank.
// The arbiter connects through the slave modport. The master modport is the client/bank side.
interface sram_bank_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 10
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]              rsp_rdata;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_wdata;
  logic [WIDTH-1:0]              mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter that shares one 1-cycle-latency SRAM bank among NUM_REQ requesters.
// It supports a burst lock that is forcibly released after BURST_MAX beats, and it routes read data back to the issuer.
module sram_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_MAX  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_bank_arbiter_if.slave     bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 accept;
  logic                 lock_hold;

  // The lock only binds while its owner keeps requesting. Otherwise the cycle falls back to round-robin.
  assign lock_hold = (state_q == LOCKED) && bus.req_valid[owner_q];

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    if (!rst) begin
      if (lock_hold) begin
        gnt[owner_q] = 1'b1;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (int'(ptr_q) + k) % NUM_REQ;
          if ((gnt == '0) && bus.req_valid[j]) gnt[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  assign accept        = |(bus.req_valid & gnt);
  assign bus.req_ready = gnt;
  assign bus.mem_en    = accept;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.mem_we    = bus.req_we[i];
        bus.mem_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // The bank's read data is valid one cycle after accept, which matches the registered rsp_valid.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bus.mem_rdata;

  always_comb begin
    state_d     = IDLE;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = '0;
    rsp_valid_d = gnt & ~bus.req_we;
    if (accept) begin
      ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      if (lock_hold) begin
        beat_cnt_d = beat_cnt_q + CW'(1);
        if (bus.req_lock[owner_q] && ((int'(beat_cnt_q) + 1) < BURST_MAX)) state_d = LOCKED;
      end else if (bus.req_lock[gnt_idx] && (BURST_MAX > 1)) begin
        state_d    = LOCKED;
        owner_d    = gnt_idx;
        beat_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed and randomized checks of sram_bank_arbiter against hand-computed vectors and a behavioural model.
module tb_sram_bank_arbiter;
  localparam int NR    = 4;
  localparam int W     = 64;
  localparam int AW    = 10;
  localparam int BM    = 8;
  localparam int BOUND = (NR - 1) * BM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_bank_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  sram_bank_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Bank model: 1-cycle read latency; a write returns its own data.
  logic [W-1:0] bank [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bank[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : bank[bus.mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] we, input logic [NR-1:0] lk,
                       input logic [NR*AW-1:0] a, input logic [NR*W-1:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] we;
    logic [NR-1:0] lk;
    logic [NR-1:0] rdy;
    logic [NR-1:0] rsp;
  } vec_t;

  vec_t tbl [6];

  // Random-traffic model state
  int              m_ptr, m_owner, m_cnt;
  bit              m_locked;
  logic [NR-1:0]   pv, pwe, plk;
  logic [AW-1:0]   pa [NR];
  logic [W-1:0]    pd [NR];
  int              waitc [NR];
  logic [W-1:0]    shadow [16];
  bit              known [16];

  initial begin
    logic [NR*AW-1:0] a;
    logic [NR*W-1:0]  d;
    logic [NR-1:0]    g, exp_rsp;
    logic [W-1:0]     exp_data;
    bit               exp_known;
    int               gi;

    tbl[0] = '{v: 4'b1111, we: 4'b0000, lk: 4'b0000, rdy: 4'b0001, rsp: 4'b0000};
    tbl[1] = '{v: 4'b1111, we: 4'b0000, lk: 4'b0000, rdy: 4'b0010, rsp: 4'b0001};
    tbl[2] = '{v: 4'b1111, we: 4'b0000, lk: 4'b0000, rdy: 4'b0100, rsp: 4'b0010};
    tbl[3] = '{v: 4'b1111, we: 4'b0000, lk: 4'b0000, rdy: 4'b1000, rsp: 4'b0100};
    tbl[4] = '{v: 4'b1111, we: 4'b0000, lk: 4'b0000, rdy: 4'b0001, rsp: 4'b1000};
    tbl[5] = '{v: 4'b0000, we: 4'b0000, lk: 4'b0000, rdy: 4'b0000, rsp: 4'b0001};

    rst = 1'b1;
    drive('0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    drive(4'b1111, '0, '0, '0, '0);
    #1;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    drive('0, '0, '0, '0, '0);
    rst = 1'b0;

    // Round-robin table: all valid reads, no lock
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].we, tbl[i].lk, '0, '0);
      #1;
      chk("rr_ready", bus.req_ready, tbl[i].rdy);
      chk("rr_rsp_valid", bus.rsp_valid, tbl[i].rsp);
      chk("rr_mem_en", bus.mem_en, |tbl[i].rdy);
    end

    // Write then read of the same address by requester 1
    a = '0; a[1*AW +: AW] = AW'(5);
    d = '0; d[1*W +: W]   = 64'h0000_0000_DEAD_BEEF;
    @(negedge clk);
    drive(4'b0010, 4'b0010, '0, a, d);
    #1;
    chk("wr_ready", bus.req_ready, 4'b0010);
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 64'h5);
    chk("wr_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    drive(4'b0010, 4'b0000, '0, a, d);
    #1;
    chk("rd_ready", bus.req_ready, 4'b0010);
    chk("wr_no_rsp", bus.rsp_valid, 4'b0000);
    chk("rd_mem_we", bus.mem_we, 1'b0);
    @(negedge clk);
    drive('0, '0, '0, '0, '0);
    #1;
    chk("rd_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("rd_rsp_rdata", bus.rsp_rdata, 64'hDEAD_BEEF);
    chk("idle_mem_addr", bus.mem_addr, 64'h0);

    // Requester 2 is locked for BURST_MAX beats, then requester 0 is served
    for (int c = 0; c <= BM; c++) begin
      @(negedge clk);
      drive(4'b0101, '0, 4'b0100, '0, '0);
      #1;
      chk("burst_ready", bus.req_ready, (c < BM) ? 4'b0100 : 4'b0001);
    end
    @(negedge clk);
    drive('0, '0, '0, '0, '0);

    // Requester 3 locks, then drops valid after 3 beats
    @(negedge clk);
    drive(4'b1000, '0, 4'b1000, '0, '0);
    #1;
    chk("drop_beat1", bus.req_ready, 4'b1000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(4'b1010, '0, 4'b1000, '0, '0);
      #1;
      chk("drop_locked_out", bus.req_ready, 4'b1000);
    end
    @(negedge clk);
    drive(4'b0010, '0, 4'b1000, '0, '0);
    #1;
    chk("drop_same_cycle", bus.req_ready, 4'b0010);
    @(negedge clk);
    drive(4'b1100, '0, '0, '0, '0);
    #1;
    chk("drop_back_idle", bus.req_ready, 4'b0100);
    @(negedge clk);
    drive('0, '0, '0, '0, '0);

    // Reset in the middle of a locked burst with a read in flight
    @(negedge clk);
    drive(4'b0100, '0, 4'b0100, '0, '0);
    #1;
    chk("rstb_beat1", bus.req_ready, 4'b0100);
    @(negedge clk);
    #1;
    chk("rstb_beat2", bus.req_ready, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstb_ready", bus.req_ready, 4'b0000);
    chk("rstb_mem_en", bus.mem_en, 1'b0);
    chk("rstb_inflight", bus.rsp_valid, 4'b0100);
    @(negedge clk);
    #1;
    chk("rstb_rsp_cleared", bus.rsp_valid, 4'b0000);
    chk("rstb_ready2", bus.req_ready, 4'b0000);
    chk("rstb_mem_en2", bus.mem_en, 1'b0);
    rst = 1'b0;
    drive(4'b1111, '0, '0, '0, '0);
    #1;
    chk("rstb_restart0", bus.req_ready, 4'b0001);
    @(negedge clk);
    #1;
    chk("rstb_restart1", bus.req_ready, 4'b0010);
    chk("rstb_rsp0", bus.rsp_valid, 4'b0001);

    // Random traffic against the behavioural model
    rst = 1'b1;
    drive('0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    pv = '0; pwe = '0; plk = '0;
    exp_rsp = '0; exp_data = '0; exp_known = 1'b0;
    for (int i = 0; i < NR; i++) begin
      waitc[i] = 0; pa[i] = '0; pd[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      known[i] = 1'b0; shadow[i] = '0;
    end

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && ($urandom_range(0, 99) < 80)) begin
          pv[i]  = 1'b1;
          pwe[i] = ($urandom_range(0, 2) == 0);
          plk[i] = ($urandom_range(0, 3) != 0);
          pa[i]  = AW'($urandom_range(0, 15));
          pd[i]  = {$urandom, $urandom};
        end
      end
      for (int i = 0; i < NR; i++) begin
        a[i*AW +: AW] = pa[i];
        d[i*W +: W]   = pd[i];
      end
      drive(pv, pwe, plk, a, d);
      #1;

      g  = '0;
      gi = -1;
      if (m_locked && pv[m_owner]) begin
        gi = m_owner;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (gi < 0 && pv[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
        end
      end
      if (gi >= 0) g[gi] = 1'b1;

      chk("rand_ready", bus.req_ready, g);
      chk("rand_rsp_valid", bus.rsp_valid, exp_rsp);
      if (exp_rsp != '0 && exp_known) chk("rand_rdata", bus.rsp_rdata, exp_data);

      exp_rsp = '0;
      if (gi >= 0) begin
        if (m_locked && pv[m_owner] && gi == m_owner) begin
          m_cnt++;
          m_locked = plk[gi] && (m_cnt < BM);
        end else begin
          m_locked = plk[gi] && (BM > 1);
          m_owner  = gi;
          m_cnt    = 1;
        end
        m_ptr = (gi + 1) % NR;
        if (pwe[gi]) begin
          shadow[pa[gi][3:0]] = pd[gi];
          known[pa[gi][3:0]]  = 1'b1;
        end else begin
          exp_rsp[gi] = 1'b1;
          exp_data    = shadow[pa[gi][3:0]];
          exp_known   = known[pa[gi][3:0]];
        end
      end else begin
        m_locked = 1'b0;
      end

      for (int i = 0; i < NR; i++) begin
        if (pv[i] && bus.req_ready[i]) begin
          chk("rand_wait_bound", (waitc[i] > BOUND) ? 1'b1 : 1'b0, 1'b0);
          waitc[i] = 0;
          pv[i]    = 1'b0;
        end else if (pv[i]) begin
          waitc[i]++;
          if (waitc[i] == BOUND + 1) chk("rand_starved", 1'b1, 1'b0);
        end
      end
    end

    @(negedge clk);
    drive('0, '0, '0, '0, '0);
    #1;
    chk("rand_final_rsp", bus.rsp_valid, exp_rsp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
